// File: rtl/music_pkg.sv
// music_pkg: shared state encoding, end marker and entry field layout helpers
package music_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;
  localparam logic [31:0] END_MARK = '1;
  function automatic int beat_lsb(input int note_w);
    return note_w;
  endfunction
  function automatic int rest_pos(input int note_w, input int beat_w);
    return note_w + beat_w;
  endfunction
  function automatic int entry_w(input int note_w, input int beat_w);
    return note_w + beat_w + 1;
  endfunction
endpackage

// File: rtl/music_sequencer_if.sv
// music_sequencer_if: control inputs and note outputs of the sequencer
interface music_sequencer_if #(
  parameter int NOTE_W = 3,
  parameter int BEAT_W = 4,
  parameter int ADDR_W = 6,
  parameter int SONG_W = 1
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop;
  logic [SONG_W-1:0] song_sel;
  logic [1:0]        tempo_shift;
  logic [NOTE_W-1:0] note_out;
  logic [BEAT_W-1:0] beat_out;
  logic              rest_out;
  logic              tone_en;
  logic              note_strobe;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] addr_out;
  modport master (
    output start, stop, pause, loop, song_sel, tempo_shift,
    input  note_out, beat_out, rest_out, tone_en, note_strobe, done, busy, addr_out
  );
  modport slave (
    input  start, stop, pause, loop, song_sel, tempo_shift,
    output note_out, beat_out, rest_out, tone_en, note_strobe, done, busy, addr_out
  );
endinterface

// File: rtl/music_song_rom.sv
// music_song_rom: combinational song table addressed by {song, entry}
module music_song_rom import music_pkg::*; #(
  parameter int NOTE_W = 3,
  parameter int BEAT_W = 4,
  parameter int ADDR_W = 6,
  parameter int SONG_W = 1
) (
  input  logic [SONG_W+ADDR_W-1:0]            i_addr,
  output logic [entry_w(NOTE_W, BEAT_W)-1:0]  o_entry
);
  localparam int EW = entry_w(NOTE_W, BEAT_W);
  function automatic logic [EW-1:0] ent(input int r, input int b, input int n);
    return {1'(r), BEAT_W'(b), NOTE_W'(n)};
  endfunction
  localparam logic [EW-1:0] TWINKLE [14] = '{
    ent(0, 2, 0), ent(0, 2, 0), ent(0, 2, 4), ent(0, 2, 4), ent(0, 2, 5), ent(0, 2, 5), ent(0, 4, 4),
    ent(0, 2, 3), ent(0, 2, 3), ent(0, 2, 2), ent(0, 2, 2), ent(0, 2, 1), ent(0, 2, 1), ent(0, 4, 0)
  };
  localparam logic [EW-1:0] SCALE [9] = '{
    ent(0, 1, 0), ent(0, 1, 1), ent(0, 1, 2), ent(0, 1, 3), ent(0, 1, 4),
    ent(0, 1, 5), ent(0, 1, 6), ent(0, 1, 7), ent(1, 2, 0)
  };
  logic [SONG_W-1:0] w_song;
  logic [ADDR_W-1:0] w_idx;
  assign w_song  = i_addr[SONG_W+ADDR_W-1:ADDR_W];
  assign w_idx   = i_addr[ADDR_W-1:0];
  assign o_entry = (w_song == '0 && w_idx < ADDR_W'(14)) ? TWINKLE[w_idx[3:0]] :
                   (w_song == SONG_W'(1) && w_idx < ADDR_W'(9)) ? SCALE[w_idx[3:0]] : '1;
endmodule

// File: rtl/music_sequencer.sv
// music_sequencer: multi-song note sequencer with pause, loop and tempo control
module music_sequencer import music_pkg::*; #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BEAT_FREQ = 4,
  parameter int NOTE_W    = 3,
  parameter int BEAT_W    = 4,
  parameter int ADDR_W    = 6,
  parameter int SONG_W    = 1
) (
  input logic               clk,
  input logic               rst_n,
  music_sequencer_if.slave  bus
);
  localparam int EW = entry_w(NOTE_W, BEAT_W);
  localparam int BL = beat_lsb(NOTE_W);
  localparam int RP = rest_pos(NOTE_W, BEAT_W);
  localparam logic [31:0] BASE_CYCLES = 32'(CLK_FREQ / BEAT_FREQ);
  state_t            r_state, w_state;
  logic [SONG_W-1:0] r_song, w_song;
  logic [ADDR_W-1:0] r_addr, w_addr, r_addr_out;
  logic [31:0]       r_clk_cnt, w_clk_cnt, w_period;
  logic [BEAT_W-1:0] r_beat_cnt, w_beat_cnt, r_beat;
  logic [1:0]        r_shift, w_shift;
  logic [NOTE_W-1:0] r_note;
  logic [EW-1:0]     w_entry;
  logic              r_new, w_new, w_done, w_end, w_wrap, w_active, w_load;
  logic              r_rest, r_tone, r_strobe, r_done, r_busy;
  music_song_rom #(.NOTE_W(NOTE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .SONG_W(SONG_W)) u_rom (
    .i_addr  ({r_song, r_addr}),
    .o_entry (w_entry)
  );
  assign w_active = r_state == S_PLAY || r_state == S_PAUSE;
  assign w_period = BASE_CYCLES >> r_shift;
  assign w_wrap   = r_clk_cnt == w_period - 32'd1;
  assign w_end    = w_entry == END_MARK[EW-1:0];
  assign w_load   = w_active && !w_end;
  // next state: stop beats start; a beat field of 0 ends after one beat since beat_cnt starts at 1
  always_comb begin
    w_state    = r_state;
    w_song     = r_song;
    w_addr     = r_addr;
    w_clk_cnt  = r_clk_cnt;
    w_beat_cnt = r_beat_cnt;
    w_shift    = r_shift;
    w_new      = 1'b0;
    w_done     = 1'b0;
    if (bus.stop) begin
      w_state = S_IDLE;
      w_addr  = '0;
    end else if (bus.start) begin
      w_state    = S_PLAY;
      w_song     = bus.song_sel;
      w_addr     = '0;
      w_clk_cnt  = '0;
      w_beat_cnt = BEAT_W'(1);
      w_shift    = bus.tempo_shift;
      w_new      = 1'b1;
    end else if (w_active && bus.pause) begin
      w_state = S_PAUSE;
    end else if (w_active) begin
      w_state = S_PLAY;
      if (w_end) begin
        if (bus.loop && r_addr != '0) begin
          w_addr = '0;
          w_new  = 1'b1;
        end else begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end
      end else if (w_wrap) begin
        w_clk_cnt = '0;
        w_shift   = bus.tempo_shift;
        if (r_beat_cnt >= w_entry[RP-1:BL]) begin
          w_addr     = r_addr + ADDR_W'(1);
          w_beat_cnt = BEAT_W'(1);
          w_new      = 1'b1;
        end else begin
          w_beat_cnt = r_beat_cnt + BEAT_W'(1);
        end
      end else begin
        w_clk_cnt = r_clk_cnt + 32'd1;
      end
    end
  end
  // sequencing state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_song     <= '0;
      r_addr     <= '0;
      r_clk_cnt  <= '0;
      r_beat_cnt <= BEAT_W'(1);
      r_shift    <= '0;
      r_new      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_song     <= w_song;
      r_addr     <= w_addr;
      r_clk_cnt  <= w_clk_cnt;
      r_beat_cnt <= w_beat_cnt;
      r_shift    <= w_shift;
      r_new      <= w_new;
    end
  end
  // registered outputs; the end marker is never shown so IDLE/DONE keep the last real entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_rest, r_beat, r_note} <= '0;
      r_addr_out <= '0;
      r_tone     <= 1'b0;
      r_strobe   <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_load) {r_rest, r_beat, r_note} <= w_entry;
      r_addr_out <= r_addr;
      r_tone     <= w_state == S_PLAY && !(w_load ? w_entry[RP] : r_rest);
      r_strobe   <= r_new && w_load;
      r_done     <= w_done;
      r_busy     <= w_state == S_PLAY || w_state == S_PAUSE;
    end
  end
  assign bus.note_out    = r_note;
  assign bus.beat_out    = r_beat;
  assign bus.rest_out    = r_rest;
  assign bus.tone_en     = r_tone;
  assign bus.note_strobe = r_strobe;
  assign bus.done        = r_done;
  assign bus.busy        = r_busy;
  assign bus.addr_out    = r_addr_out;
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: scoreboard bench for music_sequencer with BASE_CYCLES = 4
module tb_music_sequencer;
  typedef struct {int note; int beat; int rest; int addr; int gap;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_strobe = 0;
  int t_done = 0;
  int n_done = 0;
  int tone_rest_bad = 0;
  int saved_done;
  music_sequencer_if #(.NOTE_W(3), .BEAT_W(4), .ADDR_W(6), .SONG_W(1)) bus ();
  music_sequencer #(
    .CLK_FREQ(16), .BEAT_FREQ(4), .NOTE_W(3), .BEAT_W(4), .ADDR_W(6), .SONG_W(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic push(input int note, input int beat, input int rest, input int addr, input int gap);
    sb.push_back('{note, beat, rest, addr, gap});
  endtask
  task automatic push_scale(input int gap4);
    for (int i = 0; i < 8; i++) push(i, 1, 0, i, (i == 0) ? 0 : (i == 4 ? gap4 : 4));
    push(0, 2, 1, 8, 4);
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    int k = 0;
    while (!bus.done && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", int'(bus.done), 1);
    @(negedge clk);
  endtask
  task automatic wait_sb(input int lim);
    int k = 0;
    while (sb.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("sb_drain", sb.size(), 0);
  endtask
  task automatic wait_note(input int n, input int lim);
    int k = 0;
    while (!(bus.note_strobe && int'(bus.note_out) == n) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("wait_note", int'(k < lim), 1);
  endtask
  // monitor: pops the scoreboard on each strobe and tracks done pulses
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.tone_en && bus.rest_out) tone_rest_bad++;
    if (bus.done) begin
      n_done++;
      t_done = cyc;
    end
    if (bus.note_strobe) begin
      if (sb.size() == 0) chk("strobe_unexp", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("note", int'(bus.note_out), e.note);
        chk("beat", int'(bus.beat_out), e.beat);
        chk("rest", int'(bus.rest_out), e.rest);
        chk("addr", int'(bus.addr_out), e.addr);
        if (e.gap != 0) chk("gap", cyc - t_strobe, e.gap);
      end
      t_strobe = cyc;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.pause = 1'b0;
    bus.loop = 1'b0;
    bus.song_sel = 1'b1;
    bus.tempo_shift = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_note", int'(bus.note_out), 0);
    chk("rst_beat", int'(bus.beat_out), 0);
    chk("rst_rest", int'(bus.rest_out), 0);
    chk("rst_tone", int'(bus.tone_en), 0);
    chk("rst_strobe", int'(bus.note_strobe), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_addr", int'(bus.addr_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    push_scale(4);
    pulse_start();
    wait_done(200);
    chk("end_busy", int'(bus.busy), 0);
    chk("end_tone", int'(bus.tone_en), 0);
    chk("hold_rest", int'(bus.rest_out), 1);
    chk("rest_len", t_done - t_strobe, 8);
    repeat (5) @(negedge clk);
    chk("done_once", n_done, 1);
    bus.loop = 1'b1;
    push_scale(4);
    push(0, 1, 0, 0, 0);
    push(1, 1, 0, 1, 4);
    pulse_start();
    wait_sb(200);
    pulse_stop();
    bus.loop = 1'b0;
    @(negedge clk);
    chk("loop_nodone", n_done, 1);
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_addr", int'(bus.addr_out), 0);
    push_scale(14);
    pulse_start();
    wait_note(3, 100);
    chk("play_tone", int'(bus.tone_en), 1);
    bus.pause = 1'b1;
    repeat (3) @(negedge clk);
    chk("pause_note", int'(bus.note_out), 3);
    chk("pause_addr", int'(bus.addr_out), 3);
    chk("pause_tone", int'(bus.tone_en), 0);
    chk("pause_busy", int'(bus.busy), 1);
    repeat (7) @(negedge clk);
    bus.pause = 1'b0;
    wait_done(200);
    for (int i = 0; i < 4; i++) push(i, 1, 0, i, (i == 0) ? 0 : 4);
    for (int i = 4; i < 8; i++) push(i, 1, 0, i, 1);
    push(0, 2, 1, 8, 1);
    pulse_start();
    wait_note(2, 100);
    bus.tempo_shift = 2'd2;
    wait_done(200);
    chk("fast_rest", t_done - t_strobe, 2);
    bus.tempo_shift = 2'd0;
    push(0, 1, 0, 0, 0);
    pulse_start();
    wait_sb(50);
    saved_done = n_done;
    bus.stop = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("ss_busy", int'(bus.busy), 0);
    chk("ss_addr", int'(bus.addr_out), 0);
    repeat (6) @(negedge clk);
    chk("ss_nodone", n_done, saved_done);
    push(0, 1, 0, 0, 0);
    push(1, 1, 0, 1, 4);
    pulse_start();
    wait_sb(50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_note", int'(bus.note_out), 0);
    chk("arst_beat", int'(bus.beat_out), 0);
    chk("arst_addr", int'(bus.addr_out), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_tone", int'(bus.tone_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.song_sel = 1'b0;
    @(negedge clk);
    push(0, 2, 0, 0, 0);
    push(0, 2, 0, 1, 8);
    pulse_start();
    wait_sb(50);
    pulse_stop();
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("tone_rest", tone_rest_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/music_sequencer.md
# music_sequencer

Parametrised multi-song note sequencer, successor to the single-song player. It steps through a selectable song stored in an internal ROM and drives a note code onto the CD4051 resistor-select lines for the 555 tone generator. It adds start/stop/pause control, loop mode, a runtime tempo multiplier, a tone-enable (4051 inhibit) output, and a per-note strobe. All outputs are registered.

## Interface
- CLK_FREQ, 50_000_000, system clock in Hz
- BEAT_FREQ, 4, base beats per second at tempo_shift=0
- NOTE_W, 3, note code width (decoder address)
- BEAT_W, 4, beat-length field width
- ADDR_W, 6, entry address width per song
- SONG_W, 1, song-select width (2^SONG_W songs)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse: (re)start the selected song from entry 0
- stop  in  1  pulse: abort to IDLE
- pause  in  1  level: hold playback while high
- loop  in  1  level: wrap to entry 0 at the end marker instead of finishing
- song_sel  in  SONG_W  song index, sampled on start
- tempo_shift  in  2  beat period = BASE_CYCLES >> tempo_shift (x1/x2/x4/x8 speed), sampled every beat boundary
- note_out  out  NOTE_W  current note code
- beat_out  out  BEAT_W  beat length of current entry
- rest_out  out  1  current entry is a rest
- tone_en  out  1  state==PLAY && !rest_out; drives 4051 inhibit (active-low externally)
- note_strobe  out  1  one-cycle pulse when a new entry becomes current
- done  out  1  one-cycle pulse on entering DONE
- busy  out  1  state is PLAY or PAUSE
- addr_out  out  ADDR_W  current entry address

## Operation
- Entry format {rest, beat[BEAT_W-1:0], note[NOTE_W-1:0]}; end marker is all ones. ROM address = {song_q, addr}.
- BASE_CYCLES = CLK_FREQ/BEAT_FREQ; period counter clk_cnt is 32 bits. beat field 0 is treated as 1.
- States: IDLE, PLAY, PAUSE, DONE.
- IDLE/DONE --start--> PLAY: song_q<=song_sel, addr<=0, clk_cnt<=0, beat_cnt<=1.
- PLAY: clk_cnt counts to period-1, then wraps; at the wrap, if beat_cnt >= beat, addr increments and beat_cnt<=1, else beat_cnt increments.
- PLAY with the current ROM entry == end marker: if loop and addr!=0, addr<=0 with no beat time spent. Otherwise go to DONE and pulse done. An empty song ends even with loop set.
- PLAY --pause=1--> PAUSE: counters frozen, tone_en=0. PAUSE --pause=0--> PLAY: playback resumes exactly where it stopped.
- stop in any state goes to IDLE with addr<=0. If stop and start arrive in the same cycle, stop wins.
- start in PLAY/PAUSE restarts from entry 0 with song_sel re-sampled; note_strobe fires.
- In IDLE/DONE: note_out, beat_out and rest_out hold their last values, and tone_en=0.

## Timing
- Reset values: state IDLE, addr 0, song_q 0, clk_cnt 0, beat_cnt 1, all outputs 0.
- note_out, beat_out, rest_out and addr_out are registered from the ROM entry at addr, with one cycle of latency after addr changes.
- note_strobe is high in the first cycle the new entry appears on note_out. This includes entry 0 after start and after a loop wrap.
- done is high in the cycle after the end marker is detected; busy falls in the same cycle.
- A full entry lasts beat × (BASE_CYCLES >> tempo_shift) cycles. A tempo change takes effect at the next beat boundary.
- Reset mid-song forces IDLE immediately, asynchronously.

## Structure
- Shared package music_pkg holds the state encoding, the end-marker constant, and the entry field offsets derived from NOTE_W/BEAT_W.
- Sub-module music_song_rom (combinational, addr {song, entry}):
  - song 0: Twinkle Twinkle.
  - song 1: notes 0..7, beat 1 each, then rest beat 2 (8'h90), then end.
  - remaining entries: end marker.

## Test plan
Benches use CLK_FREQ=16, BEAT_FREQ=4, so BASE_CYCLES=4.
- song_sel=1, start, loop=0, tempo_shift=0:
  - notes 0..7 at 4 cycles each, then rest_out=1 for 8 cycles.
  - done pulses once; busy=0; tone_en=0 during the rest.
- song_sel=1, loop=1: after the rest, addr_out returns to 0, note_strobe fires, note_out=0, and no done pulse.
- pause for 10 cycles during note 3: note_out stays 3, tone_en=0, and the remaining duration of note 3 is unchanged after release.
- tempo_shift=2 during song 1: each 1-beat note lasts 1 cycle from the next beat boundary.
- stop and start in the same cycle: goes to IDLE, addr_out=0, busy=0.
- Reset asserted mid-song: all outputs 0 asynchronously; start after release plays song 0 first entry Do (note 0, beat 2).
